// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path: FSM state
// encoding, instruction field codes, ALU operation codes and the bit
// layout of control_bus as seen by data_path.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALUOp: what the FSM asks of the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    // ALUControl: operation select presented to the ALU
    localparam logic [2:0] ALUCTL_AND = 3'b000;
    localparam logic [2:0] ALUCTL_OR  = 3'b001;
    localparam logic [2:0] ALUCTL_ADD = 3'b010;
    localparam logic [2:0] ALUCTL_SUB = 3'b110;
    localparam logic [2:0] ALUCTL_SLT = 3'b111;

    // control_bus bit positions, shared with data_path
    localparam int CB_WIDTH      = 15;
    localparam int CB_IORD       = 14;
    localparam int CB_MEMWRITE   = 13;
    localparam int CB_IRWRITE    = 12;
    localparam int CB_PCEN       = 11;
    localparam int CB_ALUSRCA    = 10;
    localparam int CB_REGWRITE   = 9;
    localparam int CB_REGDST     = 8;
    localparam int CB_MEMTOREG   = 7;
    localparam int CB_PCSRC_HI   = 6;
    localparam int CB_PCSRC_LO   = 5;
    localparam int CB_ALUSRCB_HI = 4;
    localparam int CB_ALUSRCB_LO = 3;
    localparam int CB_ALUCTL_HI  = 2;
    localparam int CB_ALUCTL_LO  = 0;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> data_path signal bundle: instruction fields and zero flag
// flow in, the packed control word and debug state flow out.
interface multicycle_controller_if;
    import mips_ctrl_pkg::*;

    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic                zero;
    logic [CB_WIDTH-1:0] control_bus;
    logic [3:0]          state;

    // data_path side
    modport master (output opcode, funct, zero, input control_bus, state);
    // controller side
    modport slave  (input opcode, funct, zero, output control_bus, state);
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps the FSM's ALUOp and the instruction funct field to
// the 3-bit ALUControl select. Purely combinational.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_control_o
);

    // Fixed add/sub for address and branch math, funct decode for R-type
    always_comb begin
        alu_control_o = ALUCTL_ADD;
        case (alu_op_i)
            ALUOP_ADD:  alu_control_o = ALUCTL_ADD;
            ALUOP_SUB:  alu_control_o = ALUCTL_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FN_ADD:  alu_control_o = ALUCTL_ADD;
                    FN_SUB:  alu_control_o = ALUCTL_SUB;
                    FN_AND:  alu_control_o = ALUCTL_AND;
                    FN_OR:   alu_control_o = ALUCTL_OR;
                    FN_SLT:  alu_control_o = ALUCTL_SLT;
                    default: alu_control_o = ALUCTL_ADD;
                endcase
            end
            ALUOP_RSVD: alu_control_o = ALUCTL_ADD;
            default:    alu_control_o = ALUCTL_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle MIPS core. The state register is the
// only storage; control_bus is decoded from state, with PCEn additionally
// depending on the ALU zero flag so a taken beq updates PC in BRANCH.
module multicycle_controller
    import mips_ctrl_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    multicycle_controller_if.slave    ctrl_if
);

    state_t state_q, state_d;

    logic       iord, mem_write, ir_write, pc_write, branch;
    logic       alu_src_a, reg_write, reg_dst, mem_to_reg, legal;
    logic [1:0] pc_src, alu_src_b, alu_op;
    logic [2:0] alu_control;
    logic       pc_en;

    // State register; reset returns to FETCH from anywhere
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next-state logic; illegal codes recover to FETCH
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (ctrl_if.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (ctrl_if.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_d = S_MEMWB;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ADDIEXEC: state_d = S_ADDIWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Moore control decode per state
    always_comb begin
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        alu_src_a  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        pc_src     = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = ALUOP_ADD;
        legal      = 1'b1;
        case (state_q)
            S_FETCH: begin
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = 2'b01;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR, S_ADDIEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op_i      (alu_op),
        .funct_i       (ctrl_if.funct),
        .alu_control_o (alu_control)
    );

    assign pc_en = pc_write | (branch & ctrl_if.zero);

    // Pack the control word; illegal states drive an all-zero bus
    always_comb begin
        ctrl_if.control_bus = '0;
        if (legal) begin
            ctrl_if.control_bus[CB_IORD]                      = iord;
            ctrl_if.control_bus[CB_MEMWRITE]                  = mem_write;
            ctrl_if.control_bus[CB_IRWRITE]                   = ir_write;
            ctrl_if.control_bus[CB_PCEN]                      = pc_en;
            ctrl_if.control_bus[CB_ALUSRCA]                   = alu_src_a;
            ctrl_if.control_bus[CB_REGWRITE]                  = reg_write;
            ctrl_if.control_bus[CB_REGDST]                    = reg_dst;
            ctrl_if.control_bus[CB_MEMTOREG]                  = mem_to_reg;
            ctrl_if.control_bus[CB_PCSRC_HI:CB_PCSRC_LO]      = pc_src;
            ctrl_if.control_bus[CB_ALUSRCB_HI:CB_ALUSRCB_LO]  = alu_src_b;
            ctrl_if.control_bus[CB_ALUCTL_HI:CB_ALUCTL_LO]    = alu_control;
        end
    end

    assign ctrl_if.state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: each instruction pushes its
// expected state trace into a queue; a compare process checks state and
// control_bus every cycle against a per-state model of the control word.
module tb_multicycle_controller;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_controller_if ctrl_if ();

    multicycle_controller dut (
        .clk     (clk),
        .reset   (reset),
        .ctrl_if (ctrl_if)
    );

    int          tests = 0;
    int          fails = 0;
    int          exp_q[$];
    int          st_exp;
    logic [14:0] bus_exp;
    logic [14:0] seen_bus [16];
    int          mw_cnt = 0;
    int          rw_cnt = 0;

    // Model: expected ALU select for an R-type funct
    function automatic logic [2:0] model_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Model: expected control word for a state number
    function automatic logic [14:0] model_bus(input int st, input logic [5:0] fn, input logic z);
        case (st)
            0:  return 15'h180A;
            1:  return 15'h001A;
            2:  return 15'h0412;
            3:  return 15'h4002;
            4:  return 15'h0282;
            5:  return 15'h6002;
            6:  return 15'h0400 | {12'h000, model_alu(fn)};
            7:  return 15'h0302;
            8:  return z ? 15'h0C26 : 15'h0426;
            9:  return 15'h0412;
            10: return 15'h0202;
            11: return 15'h0842;
            default: return 15'h0000;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: the state trace an opcode walks through, starting at FETCH
    task automatic push_states(input logic [5:0] op, output int n);
        exp_q.push_back(0);
        exp_q.push_back(1);
        case (op)
            6'b100011: begin exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(4); end
            6'b101011: begin exp_q.push_back(2); exp_q.push_back(5); end
            6'b000000: begin exp_q.push_back(6); exp_q.push_back(7); end
            6'b000100: exp_q.push_back(8);
            6'b001000: begin exp_q.push_back(9); exp_q.push_back(10); end
            6'b000010: exp_q.push_back(11);
            default: ;
        endcase
        case (op)
            6'b100011: n = 5;
            6'b101011, 6'b000000, 6'b001000: n = 4;
            6'b000100, 6'b000010: n = 3;
            default: n = 2;
        endcase
    endtask

    // Run one instruction from the start of a FETCH cycle to the next FETCH
    task automatic run_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input bit toggle_zero);
        int n;
        ctrl_if.opcode = op;
        ctrl_if.funct  = fn;
        ctrl_if.zero   = z;
        push_states(op, n);
        for (int i = 0; i < n; i++) begin
            if (toggle_zero)
                ctrl_if.zero = (op == 6'b000100 && i == 2) ? z : (i[0] ? ~z : z);
            @(posedge clk);
            #2;
        end
        ctrl_if.zero = z;
        $display("[TB] %s opcode=%b funct=%b zero=%b cycles=%0d", nm, op, fn, z, n);
    endtask

    // Compare process: every cycle with an expected state, check the DUT
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                st_exp  = exp_q.pop_front();
                bus_exp = model_bus(st_exp, ctrl_if.funct, ctrl_if.zero);
                check($sformatf("state(exp %0d)", st_exp), {28'd0, ctrl_if.state}, st_exp);
                check($sformatf("bus@state%0d", st_exp), {17'd0, ctrl_if.control_bus}, {17'd0, bus_exp});
                seen_bus[ctrl_if.state] = ctrl_if.control_bus;
                if (ctrl_if.control_bus[13]) mw_cnt++;
                if (ctrl_if.control_bus[9])  rw_cnt++;
            end
        end
    end

    initial begin
        int mw0, rw0;
        reset          = 1'b1;
        ctrl_if.opcode = 6'b000000;
        ctrl_if.funct  = 6'b000000;
        ctrl_if.zero   = 1'b0;
        for (int i = 0; i < 16; i++) seen_bus[i] = 15'h7FFF;

        // Two reset edges, check FETCH outputs while still in reset
        @(posedge clk);
        @(negedge clk);
        check("reset_state", {28'd0, ctrl_if.state}, 0);
        check("reset_bus", {17'd0, ctrl_if.control_bus}, 32'h180A);
        @(posedge clk);
        #2;
        reset = 1'b0;

        run_instr("lw", 6'b100011, 6'b000000, 1'b0, 1'b0);
        check("lw_memrd_bus", {17'd0, seen_bus[3]}, 32'h4002);
        check("lw_memwb_bus", {17'd0, seen_bus[4]}, 32'h0282);

        mw0 = mw_cnt;
        run_instr("sw", 6'b101011, 6'b000000, 1'b0, 1'b0);
        check("sw_memwr_bus", {17'd0, seen_bus[5]}, 32'h6002);
        check("sw_memwrite_cycles", mw_cnt - mw0, 1);

        run_instr("slt", 6'b000000, 6'b101010, 1'b0, 1'b0);
        check("slt_exec_bus", {17'd0, seen_bus[6]}, 32'h0407);
        check("slt_aluwb_bus", {17'd0, seen_bus[7]}, 32'h0302);
        run_instr("and", 6'b000000, 6'b100100, 1'b1, 1'b1);
        check("and_exec_bus", {17'd0, seen_bus[6]}, 32'h0400);
        run_instr("funct_other", 6'b000000, 6'b111111, 1'b0, 1'b0);
        check("other_exec_bus", {17'd0, seen_bus[6]}, 32'h0402);
        run_instr("sub", 6'b000000, 6'b100010, 1'b0, 1'b1);
        check("sub_exec_bus", {17'd0, seen_bus[6]}, 32'h0406);

        run_instr("beq_nt", 6'b000100, 6'b000000, 1'b0, 1'b0);
        check("beq_nt_bus", {17'd0, seen_bus[8]}, 32'h0426);
        run_instr("beq_t", 6'b000100, 6'b000000, 1'b1, 1'b1);
        check("beq_t_bus", {17'd0, seen_bus[8]}, 32'h0C26);
        check("decode_bus_zero_toggle", {17'd0, seen_bus[1]}, 32'h001A);

        run_instr("j", 6'b000010, 6'b000000, 1'b0, 1'b0);
        check("j_bus", {17'd0, seen_bus[11]}, 32'h0842);
        run_instr("addi", 6'b001000, 6'b000000, 1'b1, 1'b1);
        check("addi_exec_bus", {17'd0, seen_bus[9]}, 32'h0412);
        check("addi_wb_bus", {17'd0, seen_bus[10]}, 32'h0202);

        mw0 = mw_cnt;
        rw0 = rw_cnt;
        run_instr("illegal", 6'b111111, 6'b000000, 1'b0, 1'b0);
        check("illegal_memwrite", mw_cnt - mw0, 0);
        check("illegal_regwrite", rw_cnt - rw0, 0);

        // lw interrupted by reset while in MEMRD
        ctrl_if.opcode = 6'b100011;
        ctrl_if.funct  = 6'b000000;
        ctrl_if.zero   = 1'b0;
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        repeat (3) begin
            @(posedge clk);
            #2;
        end
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        $display("[TB] reset asserted in MEMRD");
        // Follow with a jump to confirm a clean restart from FETCH
        ctrl_if.opcode = 6'b000010;
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(11);
        @(negedge clk);
        check("post_reset_state", {28'd0, ctrl_if.state}, 0);
        check("post_reset_bus", {17'd0, ctrl_if.control_bus}, 32'h180A);
        repeat (3) @(posedge clk);
        #2;
        $display("[TB] j after reset");
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
